// File: rtl/keypad_emulador.sv
// keypad_emulador: behavioural stand-in for a 4x4 matrix keypad, synthesizable.
// A key code arrives over a valid/ready handshake. The matching switch then closes
// for a programmed time, with optional pseudo-random contact chatter at press and
// at release. While the switch is closed, the row line answers the column strobe.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no key pressed, key_ready high, waiting for key_valid
// BOUNCE_IN  | press chatter: contact follows LFSR bit 0 every cycle
// HOLD       | contact stably closed for HOLD_CYCLES
// BOUNCE_OUT | release chatter: contact follows LFSR bit 0 every cycle
// GAP        | contact open for GAP_CYCLES, done on the last one
module keypad_emulador #(
  parameter int WIDTH         = 4,
  parameter int HOLD_CYCLES   = 1000,
  parameter int BOUNCE_CYCLES = 64,
  parameter int GAP_CYCLES    = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_code,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [WIDTH-1:0] col,
  output logic [WIDTH-1:0] fil,
  output logic             busy,
  output logic             done
);

  // The counter must hold the largest of the three phase lengths.
  localparam int MAX_HB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_ALL = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] LD_BOUNCE = CW'(BOUNCE_CYCLES);
  localparam logic [CW-1:0] LD_GAP    = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);
  localparam logic          BOUNCE_EN = (BOUNCE_CYCLES != 0);
  localparam logic [7:0]    LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [7:0]       lfsr;
  logic [WIDTH-1:0] col_sel;
  logic [WIDTH-1:0] row_sel;
  logic             accept;
  logic             in_bounce;
  logic             cnt_last;
  logic             contact;
  logic [3:0]       key_pos;

  // Physical position of each legend on the 4x4 pad, returned as {column, row}.
  function automatic logic [3:0] decode_key(input logic [3:0] code);
    logic [3:0] pos;
    case (code)
      4'h1:    pos = {2'd0, 2'd0};
      4'h2:    pos = {2'd1, 2'd0};
      4'h3:    pos = {2'd2, 2'd0};
      4'hA:    pos = {2'd3, 2'd0};
      4'h4:    pos = {2'd0, 2'd1};
      4'h5:    pos = {2'd1, 2'd1};
      4'h6:    pos = {2'd2, 2'd1};
      4'hB:    pos = {2'd3, 2'd1};
      4'h7:    pos = {2'd0, 2'd2};
      4'h8:    pos = {2'd1, 2'd2};
      4'h9:    pos = {2'd2, 2'd2};
      4'hC:    pos = {2'd3, 2'd2};
      4'hE:    pos = {2'd0, 2'd3};
      4'h0:    pos = {2'd1, 2'd3};
      4'hF:    pos = {2'd2, 2'd3};
      default: pos = {2'd3, 2'd3};
    endcase
    return pos;
  endfunction

  assign accept    = key_valid && (state == ST_IDLE);
  assign in_bounce = (state == ST_BOUNCE_IN) || (state == ST_BOUNCE_OUT);
  assign cnt_last  = (cnt == CNT_LAST);
  assign key_pos   = decode_key(key_code);

  // State and phase counter registers; reset drops the key at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Phase sequencing; the counter reloads with the length of whichever phase is entered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (BOUNCE_EN) begin
            state_nxt = ST_BOUNCE_IN;
            cnt_nxt   = LD_BOUNCE;
          end else begin
            state_nxt = ST_HOLD;
            cnt_nxt   = LD_HOLD;
          end
        end
      end
      ST_BOUNCE_IN: begin
        if (cnt_last) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - CNT_LAST;
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          if (BOUNCE_EN) begin
            state_nxt = ST_BOUNCE_OUT;
            cnt_nxt   = LD_BOUNCE;
          end else begin
            state_nxt = ST_GAP;
            cnt_nxt   = LD_GAP;
          end
        end else begin
          cnt_nxt = cnt - CNT_LAST;
        end
      end
      ST_BOUNCE_OUT: begin
        if (cnt_last) begin
          state_nxt = ST_GAP;
          cnt_nxt   = LD_GAP;
        end else begin
          cnt_nxt = cnt - CNT_LAST;
        end
      end
      ST_GAP: begin
        if (cnt_last) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_LAST;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Chatter source: x^8+x^6+x^5+x^4+1 Fibonacci LFSR, stepping only while bouncing.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (in_bounce) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Latch the pressed key's column and row as one-hot masks on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_sel <= '0;
      row_sel <= '0;
    end else if (accept) begin
      col_sel <= WIDTH'(1) << key_pos[3:2];
      row_sel <= WIDTH'(1) << key_pos[1:0];
    end
  end

  // Outputs: the row answers the column with no register in between, like a real switch.
  always_comb begin
    key_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = (state == ST_GAP) && cnt_last;
    contact   = (state == ST_HOLD) || (in_bounce && lfsr[0]);
    fil       = '0;
    if (contact && (col == col_sel)) begin
      fil = row_sel;
    end
  end

endmodule

// File: tb/tb_keypad_emulador.sv
// tb_keypad_emulador: randomized self-checking bench. dut0 has no bounce (short
// hold/gap), dut1 has 64 cycles of chatter at each edge of the press.
module tb_keypad_emulador;

  localparam int H0 = 10;
  localparam int G0 = 5;
  localparam int B1 = 64;
  localparam int H1 = 30;
  localparam int G1 = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] kc0, kc1, col0, col1, fil0, fil1;
  logic       kv0, kv1, rdy0, rdy1, busy0, busy1, done0, done1;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  keypad_emulador #(.WIDTH(4), .HOLD_CYCLES(H0), .BOUNCE_CYCLES(0), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .reset(reset), .key_code(kc0), .key_valid(kv0), .key_ready(rdy0),
    .col(col0), .fil(fil0), .busy(busy0), .done(done0)
  );

  keypad_emulador #(.WIDTH(4), .HOLD_CYCLES(H1), .BOUNCE_CYCLES(B1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .reset(reset), .key_code(kc1), .key_valid(kv1), .key_ready(rdy1),
    .col(col1), .fil(fil1), .busy(busy1), .done(done1)
  );

  // Position of a legend on the printed pad, read left-to-right, top-to-bottom.
  function automatic int key_index(input logic [3:0] code);
    string layout;
    string hexd;
    layout = "123A456B789CE0FD";
    hexd   = "0123456789ABCDEF";
    for (int p = 0; p < 16; p++) begin
      if (layout[p] == hexd[code]) return p;
    end
    return 0;
  endfunction

  function automatic logic [3:0] col_onehot(input logic [3:0] code);
    logic [3:0] one;
    one = 4'b0001;
    return one << (key_index(code) % 4);
  endfunction

  function automatic logic [3:0] row_onehot(input logic [3:0] code);
    logic [3:0] one;
    one = 4'b0001;
    return one << (key_index(code) / 4);
  endfunction

  function automatic logic [3:0] exp_fil(input logic [3:0] code, input logic contact, input logic [3:0] c);
    return (contact && (c == col_onehot(code))) ? row_onehot(code) : 4'b0000;
  endfunction

  // Reference chatter generator: feedback is the parity of taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  // Press one key on dut0 and follow it to the end of its gap.
  task automatic run_key0(input logic [3:0] code, input int next_code);
    logic [3:0] c;
    logic       ec;
    kc0 = code;
    kv0 = 1'b1;
    n_tests++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_accept code=%h got=%b want=1", code, rdy0);
    end
    @(posedge clk); #1;
    if (next_code >= 0) begin
      kc0 = 4'(next_code);
      kv0 = 1'b1;
    end else begin
      kv0 = 1'b0;
    end
    for (int k = 1; k <= H0 + G0; k++) begin
      ec = (k <= H0);
      n_tests++;
      if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_window code=%h cyc=%0d got busy=%b ready=%b want busy=1 ready=0", code, k, busy0, rdy0);
      end
      n_tests++;
      if (done0 !== (k == H0 + G0)) begin
        n_fail++;
        $display("FAIL done_timing code=%h cyc=%0d got=%b want=%b", code, k, done0, (k == H0 + G0));
      end
      for (int j = 0; j < 3; j++) begin
        if (j == 0)      c = 4'b0001 << (k % 4);
        else if (j == 1) c = 4'($urandom_range(0, 15));
        else             c = col_onehot(code);
        col0 = c;
        #1;
        n_tests++;
        if (fil0 !== exp_fil(code, ec, c)) begin
          n_fail++;
          $display("FAIL fil code=%h cyc=%0d col=%b got=%b want=%b", code, k, c, fil0, exp_fil(code, ec, c));
        end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (busy0 !== 1'b0 || rdy0 !== 1'b1 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done code=%h got busy=%b ready=%b done=%b want 0 1 0", code, busy0, rdy0, done0);
    end
  endtask

  // Press one key on dut1 with its column strobed continuously and follow the chatter.
  task automatic run_key1(input logic [3:0] code);
    logic ec;
    int   total;
    total = 2 * B1 + H1 + G1;
    kc1 = code;
    kv1 = 1'b1;
    col1 = col_onehot(code);
    n_tests++;
    if (rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b_ready_before_accept code=%h got=%b want=1", code, rdy1);
    end
    @(posedge clk); #1;
    kv1 = 1'b0;
    for (int k = 1; k <= total; k++) begin
      if (k <= B1 || (k > B1 + H1 && k <= 2 * B1 + H1)) begin
        ec = m_lfsr[0];
        m_lfsr = lfsr_next(m_lfsr);
      end else begin
        ec = (k <= B1 + H1);
      end
      n_tests++;
      if (fil1 !== (ec ? row_onehot(code) : 4'b0000)) begin
        n_fail++;
        $display("FAIL b_fil code=%h cyc=%0d got=%b want=%b", code, k, fil1, (ec ? row_onehot(code) : 4'b0000));
      end
      n_tests++;
      if (busy1 !== 1'b1 || done1 !== (k == total)) begin
        n_fail++;
        $display("FAIL b_busy_done cyc=%0d got busy=%b done=%b want busy=1 done=%b", k, busy1, done1, (k == total));
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (busy1 !== 1'b0 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b_after_done got busy=%b ready=%b want 0 1", busy1, rdy1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kv0 = 1'b0; kv1 = 1'b0; kc0 = '0; kc1 = '0; col0 = '0; col1 = '0;
    repeat (3) @(posedge clk);
    #1;
    m_lfsr = 8'hA5;
    n_tests++;
    if (rdy0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got r0=%b b0=%b d0=%b r1=%b b1=%b d1=%b want 1 0 0 1 0 0", rdy0, busy0, done0, rdy1, busy1, done1);
    end
    for (int i = 0; i < 16; i++) begin
      col0 = 4'(i); col1 = 4'(i);
      #1;
      n_tests++;
      if (fil0 !== 4'b0000 || fil1 !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_fil col=%b got fil0=%b fil1=%b want 0000", col0, fil0, fil1);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_key0(4'h5, -1);
  endtask

  task automatic test_sweep();
    for (int code = 0; code < 16; code++) run_key0(4'(code), -1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] c1, c2;
    c1 = 4'($urandom_range(0, 15));
    c2 = 4'(c1 + 4'($urandom_range(1, 15)));
    run_key0(c1, int'(c2));
    run_key0(c2, -1);
  endtask

  task automatic test_bounce();
    run_key1(4'($urandom_range(0, 15)));
    run_key1(4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] code;
    code = 4'($urandom_range(0, 15));
    kc0 = code;
    kv0 = 1'b1;
    @(posedge clk); #1;
    kv0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    col0 = col_onehot(code);
    #1;
    n_tests++;
    if (fil0 !== row_onehot(code)) begin
      n_fail++;
      $display("FAIL hold_before_reset code=%h got=%b want=%b", code, fil0, row_onehot(code));
    end
    reset = 1'b1;
    kv0 = 1'b1;
    @(posedge clk); #1;
    m_lfsr = 8'hA5;
    n_tests++;
    if (fil0 !== 4'b0000 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abort got fil=%b busy=%b ready=%b want 0000 0 1", fil0, busy0, rdy0);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_beats_valid got busy=%b want 0", busy0);
    end
    reset = 1'b0;
    kv0 = 1'b0;
    for (int k = 0; k < H0 + G0 + 4; k++) begin
      n_tests++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL no_done_after_abort cyc=%0d got done=%b busy=%b want 0 0", k, done0, busy0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bad_col();
    logic [3:0] code;
    logic [3:0] pats [4];
    code = 4'($urandom_range(0, 15));
    pats[0] = 4'b0000;
    pats[1] = 4'b0110;
    pats[2] = 4'b1111;
    pats[3] = col_onehot(code) | 4'b1001;
    kc0 = code;
    kv0 = 1'b1;
    @(posedge clk); #1;
    kv0 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      col0 = pats[i];
      #1;
      n_tests++;
      if (fil0 !== exp_fil(code, 1'b1, pats[i])) begin
        n_fail++;
        $display("FAIL bad_col code=%h col=%b got=%b want=%b", code, pats[i], fil0, exp_fil(code, 1'b1, pats[i]));
      end
    end
    col0 = col_onehot(code);
    #1;
    n_tests++;
    if (fil0 !== row_onehot(code)) begin
      n_fail++;
      $display("FAIL good_col code=%h got=%b want=%b", code, fil0, row_onehot(code));
    end
    repeat (H0 + G0 - 1) @(posedge clk);
    #1;
    n_tests++;
    if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_col_end got ready=%b busy=%b want 1 0", rdy0, busy0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_back_to_back();
    test_bounce();
    test_reset_mid_hold();
    test_bad_col();
    test_bounce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_emulador.md
Name: keypad_emulador

Overview:
Synthesizable 4x4 matrix-keypad model: the opposite end of the column-scan / row-sense keypad interface. It accepts a key code (0x0-0xF) over a valid/ready handshake. It then "presses" the matching key for a programmable time, with optional contact bounce at press and release. While pressed, it drives the row lines according to the column lines it receives from the scanner. Used for hardware-in-loop and bench self-test of the keypad reader path without a physical keypad.

Parameters:
WIDTH, 4, matrix dimension; only 4 is legal (fixed 4x4 key map)
HOLD_CYCLES, 1000, cycles the contact is held stably closed (>=1)
BOUNCE_CYCLES, 64, cycles of pseudo-random chatter at press and at release (0 = no bounce)
GAP_CYCLES, 100, minimum released cycles after a key before the next is accepted (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key_code  in  4  hex value of key to press
key_valid  in  1  request to press key_code
key_ready  out  1  high when a new request is accepted this cycle
col  in  WIDTH  one-hot column drive from the scanner
fil  out  WIDTH  one-hot row sense back to the scanner (all zeros = nothing pressed)
busy  out  1  high from acceptance until the end of GAP
done  out  1  single-cycle pulse on the last GAP cycle

Behaviour:
- Reset: state IDLE; key_ready=1, busy=0, done=0, contact=0, fil=0, counter=0, LFSR=8'hA5. Reset mid-operation aborts immediately and fil=0 on the next cycle.
- Key map, code -> (column, row), one-hot bit index:
  - 1->(0,0), 2->(1,0), 3->(2,0), A->(3,0)
  - 4->(0,1), 5->(1,1), 6->(2,1), B->(3,1)
  - 7->(0,2), 8->(1,2), 9->(2,2), C->(3,2)
  - E->(0,3), 0->(1,3), F->(2,3), D->(3,3)
- The key is latched as col_sel/row_sel registers on acceptance.
- fil is combinational from registered state: fil = row_sel when (contact==1 and col==col_sel), else 0.
  - Multi-hot or zero col gives fil=0 unless col exactly equals col_sel.
  - No cycle of latency from col to fil (behaves like a real switch matrix).
- Handshake: acceptance occurs when key_valid && key_ready at posedge. key_ready = (state==IDLE). key_code is sampled only at acceptance. key_valid while busy is ignored; the requester holds it until accepted.
- State machine, with counter cnt reloaded on every transition:
  - IDLE: on acceptance -> BOUNCE_IN, or straight to HOLD if BOUNCE_CYCLES==0.
  - BOUNCE_IN: contact = LFSR[0] each cycle. LFSR is x^8+x^6+x^5+x^4+1 Fibonacci, advances every cycle in bounce states only. After BOUNCE_CYCLES cycles -> HOLD.
  - HOLD: contact=1 for exactly HOLD_CYCLES cycles -> BOUNCE_OUT, or GAP if BOUNCE_CYCLES==0.
  - BOUNCE_OUT: same chatter rule as BOUNCE_IN for BOUNCE_CYCLES cycles -> GAP.
  - GAP: contact=0 for GAP_CYCLES cycles. done=1 on the final GAP cycle; next cycle -> IDLE.
- Timing:
  - busy=1 in every state except IDLE.
  - Total busy duration = 2*BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES cycles.
  - Earliest next acceptance is the cycle after done.
- Counter width: $clog2 of max(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES)+1. Counts down to 1, no wrap.
- Simultaneous reset and key_valid: reset wins, request not accepted.

Test Plan:
- Reset, then key_code=4'h5 with key_valid=1 for one cycle, BOUNCE_CYCLES=0, HOLD=10, GAP=5 -> accepted. For 10 cycles, fil=4'b0010 when col=4'b0010 and fil=0 for other col values. done pulses 15 cycles after acceptance. key_ready returns high the next cycle.
- Sweep all 16 codes with a rotating one-hot col; decode with the reader's map -> each code reproduces exactly itself (e.g. 4'hE gives fil=4'b1000 only at col=4'b0001; 4'h0 gives fil=4'b1000 only at col=4'b0010).
- BOUNCE_CYCLES=64, col tied to the selected column -> fil toggles irregularly for 64 cycles, is stable high for HOLD_CYCLES, toggles for 64 cycles, then stays 0. Toggle sequence matches a reference LFSR seeded 8'hA5.
- key_valid held high with a new code during busy -> not accepted, and the current key is unchanged. The new code is accepted the cycle after done.
- Reset asserted mid-HOLD -> fil=0, busy=0, key_ready=1 on the next cycle. No done pulse.
- col=4'b0000 and col=4'b0110 during HOLD -> fil=0.
